// File: rtl/uart_transmitter_if.sv
// Byte-write / serial-line bundle for uart_transmitter.
//   TX_DATA   : byte to transmit, sampled on an accepted TX_EN
//   TX_EN     : write strobe, one byte per high cycle while TX_STATUS=1
//   TX_STATUS : 1 = holding register empty (registered)
//   TX_BUSY   : 1 = a frame is on the line (registered)
//   UART_TX   : serial line, idles high (registered)
// master = CPU-side writer, slave = transmitter.
interface uart_transmitter_if;
    logic [7:0] TX_DATA;
    logic       TX_EN;
    logic       TX_STATUS;
    logic       TX_BUSY;
    logic       UART_TX;

    modport master (
        output TX_DATA,
        output TX_EN,
        input  TX_STATUS,
        input  TX_BUSY,
        input  UART_TX
    );

    modport slave (
        input  TX_DATA,
        input  TX_EN,
        output TX_STATUS,
        output TX_BUSY,
        output UART_TX
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises bytes as 8N1 frames (start, 8 data LSB first,
// stop) with a single-entry holding register so back-to-back frames leave no
// idle gap. Bit timing is derived from sysclk: DIV = CLK_FREQ / BAUD_RATE
// cycles per bit (DIV must be >= 2).
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the last data bit and the stop bit (frame grows to 11 bit periods).
// Ports:
//   sysclk : system clock, rising edge
//   reset  : asynchronous active-low reset
//   tx_if  : slave side of uart_transmitter_if (TX_DATA, TX_EN in;
//            TX_STATUS, TX_BUSY, UART_TX out, all outputs registered)
module uart_transmitter #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic               sysclk,
    input  logic               reset,
    uart_transmitter_if.slave  tx_if
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [BIT_W-1:0] bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       hold_q,      hold_d;
    logic             hold_full_q, hold_full_d;
    logic             status_q,    status_d;
    logic             busy_q,      busy_d;
    logic             tx_q,        tx_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q,    parity_d;
`endif

    logic accept;
    logic bit_end;
    logic load;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        status_d    = status_q;
        busy_d      = busy_q;
        tx_d        = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        load        = 1'b0;
        accept      = tx_if.TX_EN && status_q;
        bit_end     = (cnt_q == CNT_LAST);

        unique case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                    if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    // A queued byte starts its frame on the very next cycle.
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Holding -> shift transfer; parity is frozen with the byte.
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d    = ^hold_q;
`endif
        end

        // A load needs hold_full_q=1, which keeps status_q=0, so accept and
        // load can never fall on the same edge.
        if (accept) begin
            hold_d      = tx_if.TX_DATA;
            hold_full_d = 1'b1;
        end

        // Status drops right after an accept but only rises one cycle after
        // the holding register was seen empty.
        status_d = accept ? 1'b0 : !hold_full_q;

        // Counter restarts on every state entry and at each bit-period end.
        if ((state_d != state_q) || bit_end || (state_q == S_IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Line level for the cycle after this edge follows the next state.
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset forces the line high immediately.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            status_q    <= 1'b1;
            busy_q      <= 1'b0;
            tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            status_q    <= status_d;
            busy_q      <= busy_d;
            tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign tx_if.TX_STATUS = status_q;
    assign tx_if.TX_BUSY   = busy_q;
    assign tx_if.UART_TX   = tx_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at DIV=16. A frame-level model
// (queue of expected line levels per cycle) is compared against the DUT on
// every falling clock edge; an independent line decoder recovers bytes for
// the directed checks.
module tb_uart_transmitter;

    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int DIV      = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS    = 11;
    localparam logic [7:0] T6_B1 = 8'h43;
    localparam logic [7:0] T6_B2 = 8'hF3;
    localparam logic [7:0] T6_B3 = 8'hA3;
`else
    localparam int NBITS    = 10;
    localparam logic [7:0] T6_B1 = 8'h43;
    localparam logic [7:0] T6_B2 = 8'hE3;
    localparam logic [7:0] T6_B3 = 8'h83;
`endif
    localparam int FRAME    = NBITS * DIV;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;

    uart_transmitter_if tx_if ();

    uart_transmitter #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .tx_if  (tx_if)
    );

    always #5 sysclk = ~sysclk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_wave[$];
    logic [7:0] m_sent_q[$];
    bit         m_hold_valid = 1'b0;
    logic [7:0] m_hold = 8'h00;
    bit         m_status = 1'b1;
    bit         m_tx = 1'b1;
    bit         m_busy = 1'b0;
    bit         m_acc;
    bit         m_hv_old;

    always @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            m_wave.delete();
            m_hold_valid = 1'b0;
            m_status     = 1'b1;
            m_tx         = 1'b1;
            m_busy       = 1'b0;
        end else begin
            m_acc    = tx_if.TX_EN && m_status;
            m_hv_old = m_hold_valid;
            if (m_wave.size() == 0 && m_hv_old) begin
                for (int r = 0; r < DIV; r++) m_wave.push_back(1'b0);
                for (int b = 0; b < 8; b++)
                    for (int r = 0; r < DIV; r++) m_wave.push_back(m_hold[b]);
                if (NBITS == 11)
                    for (int r = 0; r < DIV; r++) m_wave.push_back(^m_hold);
                for (int r = 0; r < DIV; r++) m_wave.push_back(1'b1);
                m_sent_q.push_back(m_hold);
                m_hold_valid = 1'b0;
            end
            if (m_acc) begin
                m_hold       = tx_io_data();
                m_hold_valid = 1'b1;
            end
            m_status = m_acc ? 1'b0 : !m_hv_old;
            if (m_wave.size() > 0) begin
                m_tx   = m_wave.pop_front();
                m_busy = 1'b1;
            end else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end
        end
    end

    function automatic logic [7:0] tx_io_data();
        return tx_if.TX_DATA;
    endfunction

    // Per-cycle comparison of all outputs against the model.
    always @(negedge sysclk) begin
        check("outputs{tx,status,busy}",
              32'({tx_if.UART_TX, tx_if.TX_STATUS, tx_if.TX_BUSY}),
              32'({m_tx, m_status, m_busy}));
    end

    // ---------------- line decoder ----------------
    logic [7:0] rx_q[$];
    bit         rx_par_q[$];
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    int         rx_b = 0;
    int         idle_run = 0;
    int         rx_last_gap = -1;
    logic [7:0] rx_byte = 8'h00;
    bit         rx_par = 1'b0;

    always @(negedge sysclk) begin
        if (!reset) begin
            rx_active = 1'b0;
            idle_run  = 0;
        end else if (rx_active) begin
            rx_cnt++;
            if (rx_cnt % DIV == DIV / 2) begin
                rx_b = rx_cnt / DIV;
                if (rx_b >= 1 && rx_b <= 8) begin
                    rx_byte[rx_b-1] = tx_if.UART_TX;
                end else if (NBITS == 11 && rx_b == 9) begin
                    rx_par = tx_if.UART_TX;
                end else if (rx_b == NBITS - 1) begin
                    check("stop_bit", 32'(tx_if.UART_TX), 32'd1);
                    rx_q.push_back(rx_byte);
                    rx_par_q.push_back(rx_par);
                end
            end
            if (rx_cnt == FRAME - 1) begin
                rx_active = 1'b0;
                idle_run  = 0;
            end
        end else if (tx_if.UART_TX == 1'b0) begin
            rx_active   = 1'b1;
            rx_cnt      = 0;
            rx_last_gap = idle_run;
        end else begin
            idle_run++;
        end
    end

    // ---------------- helpers ----------------
    task automatic write(input logic [7:0] b);
        tx_if.TX_DATA = b;
        tx_if.TX_EN   = 1'b1;
        @(negedge sysclk);
        tx_if.TX_EN   = 1'b0;
    endtask

    task automatic wait_status();
        int k = 0;
        while (tx_if.TX_STATUS !== 1'b1 && k < 500) begin
            @(negedge sysclk);
            k++;
        end
        if (k >= 500) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_status: TX_STATUS stuck at %b, expected 1", tx_if.TX_STATUS);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(tx_if.TX_BUSY === 1'b0 && tx_if.TX_STATUS === 1'b1 && !rx_active) && k < 2000) begin
            @(negedge sysclk);
            k++;
        end
        if (k >= 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: busy=%b status=%b, expected busy=0 status=1",
                     tx_if.TX_BUSY, tx_if.TX_STATUS);
        end
        repeat (2) @(negedge sysclk);
    endtask

    task automatic expect_rx(input string name, input logic [7:0] exp);
        if (rx_q.size() == 0) check(name, 32'h100, 32'(exp));
        else                  check(name, 32'(rx_q.pop_front()), 32'(exp));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int cnt;
        tx_if.TX_EN   = 1'b0;
        tx_if.TX_DATA = 8'h00;
        reset         = 1'b0;
        repeat (3) @(negedge sysclk);
        check("reset_tx",     32'(tx_if.UART_TX),   32'd1);
        check("reset_status", 32'(tx_if.TX_STATUS), 32'd1);
        check("reset_busy",   32'(tx_if.TX_BUSY),   32'd0);
        reset = 1'b1;
        repeat (2) @(negedge sysclk);

        // T1: single 0x55 from idle, latency and frame length
        write(8'h55);
        check("t1_tx_after_accept",     32'(tx_if.UART_TX),   32'd1);
        check("t1_status_after_accept", 32'(tx_if.TX_STATUS), 32'd0);
        check("t1_busy_after_accept",   32'(tx_if.TX_BUSY),   32'd0);
        @(negedge sysclk);
        check("t1_tx_start",     32'(tx_if.UART_TX),   32'd0);
        check("t1_busy_start",   32'(tx_if.TX_BUSY),   32'd1);
        check("t1_status_n1",    32'(tx_if.TX_STATUS), 32'd0);
        @(negedge sysclk);
        check("t1_status_n2",    32'(tx_if.TX_STATUS), 32'd1);
        cnt = 2;
        for (int k = 0; k < 400; k++) begin
            @(negedge sysclk);
            if (!tx_if.TX_BUSY) break;
            cnt++;
        end
        check("t1_busy_cycles", 32'(cnt), 32'(FRAME));
        wait_idle();
        expect_rx("t1_byte", 8'h55);

        // T2: back-to-back frames, no idle gap
        write(8'hA3);
        wait_status();
        write(8'h0F);
        wait_idle();
        expect_rx("t2_byte0", 8'hA3);
        expect_rx("t2_byte1", 8'h0F);
        check("t2_gap", 32'(rx_last_gap), 32'd0);

        // T3: write while holding full is dropped
        write(8'h11);
        wait_status();
        write(8'h22);
        write(8'h33);
        wait_idle();
        expect_rx("t3_byte0", 8'h11);
        expect_rx("t3_byte1", 8'h22);
        check("t3_no_extra", 32'(rx_q.size()), 32'd0);

        // T4: asynchronous reset during data bit 3 of 0xF0
        write(8'hF0);
        repeat (1 + 4 * DIV + 4) @(negedge sysclk);
        check("t4_bit3_low", 32'(tx_if.UART_TX), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("t4_async_tx",     32'(tx_if.UART_TX),   32'd1);
        check("t4_async_status", 32'(tx_if.TX_STATUS), 32'd1);
        check("t4_async_busy",   32'(tx_if.TX_BUSY),   32'd0);
        repeat (3) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        write(8'h3C);
        wait_idle();
        expect_rx("t4_byte", 8'h3C);
        check("t4_no_extra", 32'(rx_q.size()), 32'd0);

`ifdef UART_TX_PARITY_EN
        // T5: even parity bit
        write(8'h07);
        wait_idle();
        check("t5_par_07", 32'(rx_par_q[rx_par_q.size()-1]), 32'd1);
        expect_rx("t5_byte_07", 8'h07);
        write(8'h03);
        wait_idle();
        check("t5_par_03", 32'(rx_par_q[rx_par_q.size()-1]), 32'd0);
        expect_rx("t5_byte_03", 8'h03);
`endif

        // T6: TX_EN held high with incrementing data
        rx_q.delete();
        m_sent_q.delete();
        tx_if.TX_DATA = 8'h40;
        tx_if.TX_EN   = 1'b1;
        for (int i = 1; i < 400; i++) begin
            @(negedge sysclk);
            tx_if.TX_DATA = 8'(8'h40 + i);
        end
        @(negedge sysclk);
        tx_if.TX_EN = 1'b0;
        wait_idle();
        check("t6_count_model", 32'(rx_q.size()), 32'(m_sent_q.size()));
        for (int i = 0; i < rx_q.size() && i < m_sent_q.size(); i++)
            check("t6_byte_model", 32'(rx_q[i]), 32'(m_sent_q[i]));
        check("t6_count", 32'(rx_q.size()), 32'd4);
        expect_rx("t6_byte0", 8'h40);
        expect_rx("t6_byte1", T6_B1);
        expect_rx("t6_byte2", T6_B2);
        expect_rx("t6_byte3", T6_B3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serialises bytes onto the UART_TX line as 8N1 frames: start bit, 8 data bits LSB first, stop bit. It is the transmit-side companion of the UART receive path in the peripheral subsystem. A single-entry holding register lets the CPU bus interface queue the next byte while the current one shifts out, so consecutive frames go out with no idle gap. Bit timing comes from an internal sysclk divider, so no separate baud clock is needed.

Parameters:
CLK_FREQ, 100000000, sysclk frequency in Hz
BAUD_RATE, 9600, line bit rate in bits/s
DIV, CLK_FREQ/BAUD_RATE (integer truncation), sysclk cycles per bit; must be >= 2

Ports:
sysclk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
TX_DATA  input  8  byte to transmit; sampled on an accepted TX_EN
TX_EN  input  1  write strobe; one byte accepted per high cycle when TX_STATUS=1
TX_STATUS  output  1  1 = holding register empty (a write is accepted); registered
TX_BUSY  output  1  1 = a frame is on the line (FSM not IDLE); registered
UART_TX  output  1  serial line, idles high; registered

Behaviour:
- Clock and reset: one clock, sysclk. reset is asynchronous and active-low.
- Reset values: UART_TX=1, TX_STATUS=1, TX_BUSY=0, FSM=IDLE, holding register empty, baud counter=0, bit index=0.
- Reset mid-frame: UART_TX returns to 1 immediately (asynchronously). The frame is truncated and any held byte is discarded.
- Write acceptance: on a sysclk edge with TX_EN=1 and TX_STATUS=1, TX_DATA is copied into the holding register and TX_STATUS=0 from the next cycle.
  - TX_EN while TX_STATUS=0 is ignored. No state change; the byte is dropped.
- Baud counter:
  - Counts 0..DIV-1 and wraps; width is ceil(log2(DIV)).
  - Cleared on every state entry.
  - A bit period ends on the edge where counter=DIV-1, so every bit lasts exactly DIV cycles.
- FSM states:
  - IDLE: UART_TX=1, TX_BUSY=0. On an edge with the holding register full: move the byte into the shift register, mark holding empty (TX_STATUS=1 next cycle), go to START.
  - START: UART_TX=0 for DIV cycles, then go to DATA with bit index=0.
  - DATA: UART_TX = shift register bit 0. At each bit-period end, shift right and increment the bit index. After bit 7 completes, go to STOP (or PARITY when compiled in).
  - STOP: UART_TX=1 for DIV cycles. At the end: if holding is full, load it, mark holding empty and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: TX_EN accepted at edge n in IDLE, with holding empty:
  - edge n+1: FSM leaves IDLE; UART_TX=0 and TX_BUSY=1 are visible after edge n+1.
  - TX_STATUS returns to 1 after edge n+2.
- Frame length: exactly 10*DIV cycles, or 11*DIV with parity, measured from the UART_TX falling edge to the end of the stop bit.
- Simultaneous events:
  - The holding→shift transfer and a TX_EN on the same edge cannot both succeed, because TX_STATUS is still 0 that cycle. The write is ignored.
  - The write may be retried the following cycle.
- TX_DATA changes after acceptance do not affect the byte in flight or the held byte.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits, captured at load) for DIV cycles. The frame becomes 11*DIV cycles.
- Not defined: no PARITY state and no parity logic; the frame is 8N1.

Test Plan:
- DIV=16, write 0x55 from IDLE → UART_TX low one cycle after the accept edge; line pattern 0,1,0,1,0,1,0,1,0,1, each exactly 16 cycles; TX_BUSY low after 160 cycles; TX_STATUS back to 1 two cycles after accept.
- Write 0xA3, then 0x0F as soon as TX_STATUS=1 → two frames with no idle cycle between the 0xA3 stop bit and the 0x0F start bit; decoded bytes 0xA3, 0x0F.
- Write 0x11, then 0x22 (fills holding), then 0x33 while TX_STATUS=0 → only 0x11 and 0x22 are transmitted; 0x33 never appears.
- Assert reset low during data bit 3 of 0xF0 → UART_TX=1 without waiting for sysclk; all outputs at reset values; after release, a write of 0x3C transmits a clean frame.
- With UART_TX_PARITY_EN, write 0x07 (three ones) → parity bit=1 and frame is 11*DIV cycles. Write 0x03 → parity bit=0.
- Hold TX_EN=1 continuously with TX_DATA incrementing each cycle → only bytes sampled while TX_STATUS=1 are sent, in order, with no gaps and no corrupted frames.
